ct_idu_dep_wake_arb: RTL and testbench



---
 rtl/ct_idu_dep_pkg.sv | 21 ++
 rtl/ct_idu_dep_wake_fifo.sv | 44 ++++
 rtl/ct_idu_dep_wake_arb.sv | 112 +++++++++++
 tb/tb_ct_idu_dep_wake_arb.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ct_idu_dep_pkg.sv
// Shared types and constants for the IDU dependency late-wakeup path.
package ct_idu_dep_pkg;

    localparam int PREG_W = 7;

    localparam int SRC_DIV   = 0;
    localparam int SRC_VFPU6 = 1;
    localparam int SRC_VFPU7 = 2;
    localparam int SRC_SPARE = 3;

    typedef struct packed {
        logic              vld;
        logic [PREG_W-1:0] preg;
    } wake_slot_t;

    // v is at most 2n-1 at every call site, so a single subtract wraps it
    function automatic int wrap_src(input int v, input int n);
        return (v >= n) ? v - n : v;
    endfunction

endpackage

// File: rtl/ct_idu_dep_wake_fifo.sv
// Per-source wakeup buffer: shift-register FIFO, head always at entry 0.
// Push needs not_full; pop of an empty FIFO is never issued by the arbiter.
module ct_idu_dep_wake_fifo #(
    parameter int  DEPTH = 2,
    parameter int  W     = 7,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          dep_clk,
    input  logic          cpurst_b,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_preg,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head,
    output logic          not_full
);

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] wr_idx;

    // a same-cycle pop shifts everything down, so the write slot moves with it
    assign wr_idx   = count - CW'(pop);
    assign head     = mem[0];
    assign not_full = (count < CW'(DEPTH));

    always_ff @(posedge dep_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (wr_idx == CW'(i))) mem[i] <= push_preg;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/ct_idu_dep_wake_arb.sv
// Late-wakeup broadcast arbiter: buffers per-source preg wakeups and grants up to
// two heads per cycle round-robin onto two registered broadcast slots.
module ct_idu_dep_wake_arb
    import ct_idu_dep_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int PREG_W  = ct_idu_dep_pkg::PREG_W,
    parameter int DEPTH   = 2
) (
    input  logic                      dep_clk,
    input  logic                      cpurst_b,
    input  logic                      rtu_idu_flush_fe,
    input  logic                      rtu_idu_flush_is,
    input  logic [NUM_SRC-1:0]        src_req_vld,
    input  logic [NUM_SRC*PREG_W-1:0] src_req_preg,
    output logic [NUM_SRC-1:0]        src_req_rdy,
    output logic                      wake0_vld,
    output logic [PREG_W-1:0]         wake0_preg,
    output logic                      wake1_vld,
    output logic [PREG_W-1:0]         wake1_preg,
    output logic                      arb_idle
);

    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic               flush;
    logic [NUM_SRC-1:0] nonempty;
    logic [NUM_SRC-1:0] not_full;
    logic [NUM_SRC-1:0] pop;
    logic [PREG_W-1:0]  head [NUM_SRC];

    logic               g0_vld, g1_vld;
    logic [PW-1:0]      g0_idx, g1_idx;
    logic [PW-1:0]      rr_ptr;
    wake_slot_t         slot0, slot1;

    assign flush = rtu_idu_flush_fe | rtu_idu_flush_is;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [CW-1:0] cnt;

        ct_idu_dep_wake_fifo #(
            .DEPTH (DEPTH),
            .W     (PREG_W)
        ) u_fifo (
            .dep_clk   (dep_clk),
            .cpurst_b  (cpurst_b),
            .flush     (flush),
            .push      (src_req_vld[gi] & not_full[gi] & ~flush),
            .push_preg (src_req_preg[gi*PREG_W +: PREG_W]),
            .pop       (pop[gi]),
            .count     (cnt),
            .head      (head[gi]),
            .not_full  (not_full[gi])
        );

        assign nonempty[gi] = |cnt;
        assign pop[gi]      = (g0_vld && (g0_idx == PW'(gi))) ||
                              (g1_vld && (g1_idx == PW'(gi)));
    end

    assign src_req_rdy = not_full;

    // slot 1 searches strictly after the slot-0 winner, so it can never pick the same source
    always_comb begin
        g0_vld = 1'b0;
        g0_idx = '0;
        g1_vld = 1'b0;
        g1_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!g0_vld && nonempty[PW'(wrap_src(int'(rr_ptr) + k, NUM_SRC))]) begin
                g0_vld = 1'b1;
                g0_idx = PW'(wrap_src(int'(rr_ptr) + k, NUM_SRC));
            end
        end
        for (int k = 1; k < NUM_SRC; k++) begin
            if (g0_vld && !g1_vld && nonempty[PW'(wrap_src(int'(g0_idx) + k, NUM_SRC))]) begin
                g1_vld = 1'b1;
                g1_idx = PW'(wrap_src(int'(g0_idx) + k, NUM_SRC));
            end
        end
    end

    always_ff @(posedge dep_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rr_ptr <= '0;
            slot0  <= '0;
            slot1  <= '0;
        end else if (flush) begin
            rr_ptr    <= '0;
            slot0.vld <= 1'b0;
            slot1.vld <= 1'b0;
        end else begin
            slot0.vld <= g0_vld;
            slot1.vld <= g1_vld;
            if (g0_vld) slot0.preg <= head[g0_idx];
            if (g1_vld) slot1.preg <= head[g1_idx];
            if (g1_vld)
                rr_ptr <= PW'(wrap_src(int'(g1_idx) + 1, NUM_SRC));
            else if (g0_vld)
                rr_ptr <= PW'(wrap_src(int'(g0_idx) + 1, NUM_SRC));
        end
    end

    assign wake0_vld  = slot0.vld;
    assign wake0_preg = slot0.preg;
    assign wake1_vld  = slot1.vld;
    assign wake1_preg = slot1.preg;
    assign arb_idle   = ~|nonempty & ~slot0.vld & ~slot1.vld;

endmodule

// File: tb/tb_ct_idu_dep_wake_arb.sv
// Directed bench for the late-wakeup arbiter with hand-computed per-cycle expectations.
module tb_ct_idu_dep_wake_arb;
    import ct_idu_dep_pkg::*;

    localparam int NS = 4;
    localparam int PW = 7;

    logic            dep_clk;
    logic            cpurst_b;
    logic            rtu_idu_flush_fe;
    logic            rtu_idu_flush_is;
    logic [NS-1:0]   src_req_vld;
    logic [NS*PW-1:0] src_req_preg;
    logic [NS-1:0]   src_req_rdy;
    logic            wake0_vld;
    logic [PW-1:0]   wake0_preg;
    logic            wake1_vld;
    logic [PW-1:0]   wake1_preg;
    logic            arb_idle;

    int n_chk  = 0;
    int n_pass = 0;

    ct_idu_dep_wake_arb #(.NUM_SRC(NS), .PREG_W(PW), .DEPTH(2)) dut (
        .dep_clk          (dep_clk),
        .cpurst_b         (cpurst_b),
        .rtu_idu_flush_fe (rtu_idu_flush_fe),
        .rtu_idu_flush_is (rtu_idu_flush_is),
        .src_req_vld      (src_req_vld),
        .src_req_preg     (src_req_preg),
        .src_req_rdy      (src_req_rdy),
        .wake0_vld        (wake0_vld),
        .wake0_preg       (wake0_preg),
        .wake1_vld        (wake1_vld),
        .wake1_preg       (wake1_preg),
        .arb_idle         (arb_idle)
    );

    initial begin
        dep_clk = 1'b0;
        forever #5 dep_clk = ~dep_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge dep_clk);
        #1;
    endtask

    task automatic set_req(input int src, input logic [PW-1:0] preg);
        src_req_vld[src] = 1'b1;
        src_req_preg[src*PW +: PW] = preg;
    endtask

    task automatic slots(input string tag, input logic v0, input logic [PW-1:0] p0,
                         input logic v1, input logic [PW-1:0] p1);
        chk({tag, ".v0"}, 32'(wake0_vld), 32'(v0));
        if (v0) chk({tag, ".p0"}, 32'(wake0_preg), 32'(p0));
        chk({tag, ".v1"}, 32'(wake1_vld), 32'(v1));
        if (v1) chk({tag, ".p1"}, 32'(wake1_preg), 32'(p1));
    endtask

    initial begin
        cpurst_b         = 1'b0;
        rtu_idu_flush_fe = 1'b0;
        rtu_idu_flush_is = 1'b0;
        src_req_vld      = '0;
        src_req_preg     = '0;

        // reset state
        #3;
        chk("rst_rdy",  32'(src_req_rdy), 32'hf);
        chk("rst_idle", 32'(arb_idle), 32'h1);
        slots("rst", 1'b0, 7'h0, 1'b0, 7'h0);
        chk("rst_p0", 32'(wake0_preg), 32'h0);
        chk("rst_p1", 32'(wake1_preg), 32'h0);
        chk("rst_rr", 32'(dut.rr_ptr), 32'h0);
        #9 cpurst_b = 1'b1;
        step();
        chk("idle_after_rst", 32'(arb_idle), 32'h1);
        slots("idle", 1'b0, 7'h0, 1'b0, 7'h0);

        // single div wakeup: visible the second edge after presentation
        set_req(SRC_DIV, 7'h15);
        step();
        src_req_vld = '0;
        slots("div_t", 1'b0, 7'h0, 1'b0, 7'h0);
        chk("div_t_idle", 32'(arb_idle), 32'h0);
        step();
        slots("div_t1", 1'b1, 7'h15, 1'b0, 7'h0);
        chk("div_rr", 32'(dut.rr_ptr), 32'h1);
        step();
        slots("div_t2", 1'b0, 7'h0, 1'b0, 7'h0);
        chk("div_idle", 32'(arb_idle), 32'h1);

        // front-end flush returns rr_ptr to 0
        rtu_idu_flush_fe = 1'b1;
        step();
        rtu_idu_flush_fe = 1'b0;
        chk("fe_rr", 32'(dut.rr_ptr), 32'h0);

        // all four sources in one cycle
        set_req(0, 7'd10); set_req(1, 7'd11); set_req(2, 7'd12); set_req(3, 7'd13);
        step();
        src_req_vld = '0;
        step();
        slots("all4_a", 1'b1, 7'd10, 1'b1, 7'd11);
        chk("all4_rr_a", 32'(dut.rr_ptr), 32'h2);
        step();
        slots("all4_b", 1'b1, 7'd12, 1'b1, 7'd13);
        chk("all4_rr_b", 32'(dut.rr_ptr), 32'h0);
        step();
        slots("all4_c", 1'b0, 7'h0, 1'b0, 7'h0);

        // contention fills source 1: rdy drops, 22 held, order 20,21,22
        set_req(0, 7'h40); set_req(2, 7'h42); set_req(3, 7'h43);
        step();
        set_req(1, 7'd20);
        step();
        slots("bp_e2", 1'b1, 7'h40, 1'b1, 7'h42);
        set_req(1, 7'd21);
        chk("bp_rdy1_e3", 32'(src_req_rdy[1]), 32'h1);
        step();
        slots("bp_e3", 1'b1, 7'h43, 1'b1, 7'h40);
        set_req(1, 7'd22);
        chk("bp_rdy1_full", 32'(src_req_rdy[1]), 32'h0);
        step();
        slots("bp_e4", 1'b1, 7'd20, 1'b1, 7'h42);
        chk("bp_rdy1_back", 32'(src_req_rdy[1]), 32'h1);
        step();
        slots("bp_e5", 1'b1, 7'h43, 1'b1, 7'h40);
        src_req_vld = '0;
        step();
        slots("bp_e6", 1'b1, 7'd21, 1'b1, 7'h42);
        step();
        slots("bp_e7", 1'b1, 7'h43, 1'b1, 7'h40);
        step();
        slots("bp_e8", 1'b1, 7'd22, 1'b1, 7'h42);
        step();
        slots("bp_e9", 1'b0, 7'h0, 1'b0, 7'h0);
        chk("bp_idle", 32'(arb_idle), 32'h1);

        // issue flush with three loaded sources and a new request in the flush cycle
        set_req(0, 7'd50); set_req(1, 7'd51); set_req(2, 7'd52);
        step();
        src_req_vld = '0;
        chk("fl_loaded_idle", 32'(arb_idle), 32'h0);
        rtu_idu_flush_is = 1'b1;
        set_req(3, 7'd53);
        step();
        rtu_idu_flush_is = 1'b0;
        src_req_vld = '0;
        slots("fl_next", 1'b0, 7'h0, 1'b0, 7'h0);
        chk("fl_rdy", 32'(src_req_rdy), 32'hf);
        chk("fl_rr", 32'(dut.rr_ptr), 32'h0);
        step();
        slots("fl_after", 1'b0, 7'h0, 1'b0, 7'h0);
        chk("fl_idle", 32'(arb_idle), 32'h1);

        // same preg from two sources, no dedup
        set_req(0, 7'h33); set_req(2, 7'h33);
        step();
        src_req_vld = '0;
        step();
        slots("dup", 1'b1, 7'h33, 1'b1, 7'h33);
        step();

        // asynchronous reset with entries buffered
        set_req(0, 7'd5); set_req(1, 7'd6);
        step();
        src_req_vld = '0;
        #2 cpurst_b = 1'b0;
        #1;
        chk("arst_idle", 32'(arb_idle), 32'h1);
        chk("arst_rdy", 32'(src_req_rdy), 32'hf);
        slots("arst", 1'b0, 7'h0, 1'b0, 7'h0);
        chk("arst_p0", 32'(wake0_preg), 32'h0);
        step();
        #2 cpurst_b = 1'b1;
        step();
        slots("arst_post", 1'b0, 7'h0, 1'b0, 7'h0);
        chk("arst_post_idle", 32'(arb_idle), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
